// File: rtl/pid_bus_if.sv
// pid_bus_if: local-bus strobes, address and data between the sequencer and the register file
interface pid_bus_if;
  logic [7:0]  Address;
  logic [31:0] DataOut;
  logic [31:0] DataIn;
  logic        Write;
  logic        Read;
  modport master (output Address, DataOut, Write, Read, input DataIn);
  modport slave  (input Address, DataOut, Write, Read, output DataIn);
endinterface

// File: rtl/pid_cfg_sequencer.sv
// pid_cfg_sequencer: sweeps enabled PID channels, writing four sub-registers each.
// Build option PID_CFG_READBACK_EN adds a read-back and compare after every write.
module pid_cfg_sequencer #(
  parameter int NCH     = 6,
  parameter int RST_IDX = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [NCH-1:0] chan_mask_i,
  input  logic [31:0]    cf_val_i,
  input  logic [31:0]    ew_val_i,
  input  logic [31:0]    pw_val_i,
  input  logic [31:0]    mw_val_i,
  pid_bus_if.master      bus,
  output logic           busy_o,
  output logic           done_o,
  output logic [7:0]     err_cnt_o,
  output logic [7:0]     err_addr_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SCAN = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] DONE = 3'd5;
`ifdef PID_CFG_READBACK_EN
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] CHK  = 3'd4;
`endif
  logic [2:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [1:0]       sub_q, sub_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       eaddr_q, eaddr_d;
  logic [NCH-1:0]   mask_q;
  logic [3:0][31:0] val_q;
  logic [63:0]      mask_ext;
  logic             last, wr, rd, accept;
  logic [2:0]       adv_state;
  logic [5:0]       adv_idx;
  assign mask_ext  = 64'(mask_q);
  assign last      = idx_q == 6'(NCH - 1);
  assign accept    = state_q == IDLE && start_i;
  // Where to go once the current sub-register is finished
  assign adv_state = sub_q != 2'd3 ? WR : last ? DONE : SCAN;
  assign adv_idx   = adv_state == SCAN ? idx_q + 6'd1 : idx_q;
  assign wr        = state_q == WR;
`ifdef PID_CFG_READBACK_EN
  assign rd        = state_q == RD;
`else
  logic unused_din;
  assign rd         = 1'b0;
  assign unused_din = ^bus.DataIn;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SCAN;
        idx_d   = 6'(RST_IDX);
        sub_d   = 2'd0;
        cnt_d   = 8'd0;
        eaddr_d = 8'd0;
      end
      SCAN: begin
        state_d = mask_ext[idx_q] ? WR : last ? DONE : SCAN;
        idx_d   = mask_ext[idx_q] || last ? idx_q : idx_q + 6'd1;
        sub_d   = 2'd0;
      end
`ifdef PID_CFG_READBACK_EN
      WR: state_d = RD;
      RD: state_d = CHK;
      CHK: begin
        if (bus.DataIn != val_q[sub_q]) begin
          cnt_d   = cnt_q == 8'hff ? cnt_q : cnt_q + 8'd1;
          eaddr_d = cnt_q == 8'd0 ? {idx_q, sub_q} : eaddr_q;
        end
        state_d = adv_state;
        idx_d   = adv_idx;
        sub_d   = sub_q + 2'd1;
      end
`else
      WR: begin
        state_d = adv_state;
        idx_d   = adv_idx;
        sub_d   = sub_q + 2'd1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sub_q   <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      mask_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      if (accept) begin
        mask_q <= chan_mask_i;
        val_q  <= {mw_val_i, pw_val_i, ew_val_i, cf_val_i};
      end
    end
  end
  // Bus outputs decode straight from state so reset clears them without waiting for a clock
  assign bus.Write   = wr;
  assign bus.Read    = rd;
  assign bus.Address = wr || rd ? {idx_q, sub_q} : 8'd0;
  assign bus.DataOut = wr ? val_q[sub_q] : 32'd0;
  assign busy_o      = state_q != IDLE && state_q != DONE;
  assign done_o      = state_q == DONE;
  assign err_cnt_o   = cnt_q;
  assign err_addr_o  = eaddr_q;
endmodule

// File: tb/tb_pid_cfg_sequencer.sv
// tb_pid_cfg_sequencer: directed sweeps against an echoing register-file responder.
module tb_pid_cfg_sequencer;
`ifdef PID_CFG_READBACK_EN
  localparam int PER = 3;
`else
  localparam int PER = 1;
`endif
  logic        clk = 0, rst_n = 0, start = 0;
  logic [5:0]  chan_mask = 0;
  logic [31:0] cf = 0, ew = 0, pw = 0, mw = 0;
  logic        busy, done;
  logic [7:0]  err_cnt, err_addr;
  logic [7:0]  bad0 = 8'hff, bad1 = 8'hff;
  logic [31:0] mem [256];
  int tests = 0, fails = 0;
  pid_bus_if bus();
  pid_cfg_sequencer #(.NCH(6), .RST_IDX(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .chan_mask_i(chan_mask),
    .cf_val_i(cf), .ew_val_i(ew), .pw_val_i(pw), .mw_val_i(mw),
    .bus(bus), .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt), .err_addr_o(err_addr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.Write) mem[bus.Address] <= bus.DataOut;
    bus.DataIn <= bus.Read && bus.Address != bad0 && bus.Address != bad1 ? mem[bus.Address] : 32'd0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic sweep(input logic [5:0] m, input logic [31:0] v0, v1, v2, v3, input bit mid,
                       input logic [7:0] b0, b1, input logic [7:0] exp_cnt, exp_addr);
    logic [41:0] q[$];
    logic [41:0] got, exp;
    logic [31:0] v [4];
    int nen = 0, n = 1;
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 6; i++)
      if (m[i]) begin
        nen++;
        for (int s = 0; s < 4; s++) begin
          q.push_back({2'b10, 6'(i), 2'(s), v[s]});
          if (PER == 3) q.push_back({2'b01, 6'(i), 2'(s), 32'd0});
        end
      end
    bad0 = b0;
    bad1 = b1;
    @(negedge clk);
    chan_mask = m; cf = v0; ew = v1; pw = v2; mw = v3; start = 1;
    @(negedge clk);
    start = 0; chan_mask = ~m; cf = ~v0; ew = ~v1; pw = ~v2; mw = ~v3;
    while (!done && n < 300) begin
      if (n == 1) chk("busy_first", 64'(busy), 64'd1);
      start = mid && n == 3;
      got = {bus.Write, bus.Read, bus.Address, bus.DataOut};
      if (bus.Write && bus.Read) chk("both_strobes", 64'd1, 64'd0);
      else if (bus.Write || bus.Read) begin
        exp = q.size() != 0 ? q.pop_front() : '1;
        chk("strobe", 64'(got), 64'(exp));
      end else chk("idle_bus", 64'(got[39:0]), 64'd0);
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("done_latency", 64'(n), 64'(6 + nen * 4 * PER + 1));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("strobes_left", 64'(q.size()), 64'd0);
    chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    chk("err_addr", 64'(err_addr), 64'(exp_addr));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("err_cnt_hold", 64'(err_cnt), 64'(exp_cnt));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", 64'({busy, done, err_cnt, err_addr, bus.Write, bus.Read, bus.Address, bus.DataOut}), 64'd0);
    rst_n = 1;
    sweep(6'b000001, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 0, 8'hff, 8'hff, 8'd0, 8'd0);
    sweep(6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 8'hff, 8'hff, 8'd0, 8'd0);
    sweep(6'b100001, 32'hdead_beef, 32'hcafe_f00d, 32'h0123_4567, 32'h89ab_cdef, 0, 8'h15, 8'h16,
          PER == 3 ? 8'd2 : 8'd0, PER == 3 ? 8'h15 : 8'h00);
    sweep(6'b000010, 32'h5a5a_5a5a, 32'ha5a5_a5a5, 32'h0f0f_0f0f, 32'hf0f0_f0f0, 1, 8'hff, 8'hff, 8'd0, 8'd0);
    // Reset in the middle of channel 0's first write
    @(negedge clk);
    chan_mask = 6'b000001; cf = 32'h7777_7777; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("wr_before_rst", 64'({bus.Write, bus.Address}), 64'({1'b1, 8'h00}));
    #2 rst_n = 0;
    #1 chk("async_rst", 64'({bus.Write, bus.Read, busy, bus.Address, bus.DataOut, err_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1;
    sweep(6'b000001, 32'h0000_00a0, 32'h0000_00b1, 32'h0000_00c2, 32'h0000_00d3, 0, 8'hff, 8'hff, 8'd0, 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
